// File: rtl/chip8_alu_sequencer.sv
// Multi-cycle executor for Chip-8 8XYN ALU instructions: reads Vx/Vy over one
// synchronous read port, drives an external ALU, writes Vx then VF.
package chip8_alu_pkg;
    typedef enum logic [3:0] {
        ALU_f_ADD    = 4'd0,
        ALU_f_MINUS  = 4'd1,
        ALU_f_AND    = 4'd2,
        ALU_f_OR     = 4'd3,
        ALU_f_XOR    = 4'd4,
        ALU_f_RSHIFT = 4'd5,
        ALU_f_LSHIFT = 4'd6
    } ALU_f;
endpackage

module chip8_alu_sequencer
    import chip8_alu_pkg::*;
#(
    parameter bit SHIFT_SRC_VY = 1'b0,
    parameter bit LOGIC_CLR_VF = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  rf_raddr,
    input  logic [7:0]  rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output ALU_f        alu_sel,
    input  logic [15:0] alu_out
);

    // Handshake: start is a one-cycle request sampled only in IDLE (ignored
    // otherwise, never queued); busy is high from the accepting edge through
    // the done cycle; done pulses for one cycle and illegal is valid with it.

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_X,
        S_RD_Y,
        S_EXEC,
        S_WR_V,
        S_WR_F,
        S_DONE
    } state_t;

    state_t      state;
    logic [11:0] op_q;
    logic [7:0]  vx_q;
    logic [7:0]  result_q;
    logic        flag_q;

    logic [3:0]  op_x;
    logic [3:0]  op_y;
    logic [3:0]  op_n;
    logic        flag_op;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [7:0]  shift_src;
    logic        flag_d;
    logic        unused_alu_bits;

    assign op_x = op_q[11:8];
    assign op_y = op_q[7:4];
    assign op_n = op_q[3:0];

    assign unused_alu_bits = &{1'b0, alu_out[14:9]};

    function automatic logic is_legal(input logic [15:0] op);
        return (op[15:12] == 4'h8) && ((op[3:0] <= 4'h7) || (op[3:0] == 4'hE));
    endfunction

    always_comb begin
        flag_op = 1'b0;
        case (op_n)
            4'h4, 4'h5, 4'h6, 4'h7, 4'hE: flag_op = 1'b1;
            4'h1, 4'h2, 4'h3:             flag_op = LOGIC_CLR_VF;
            default:                      flag_op = 1'b0;
        endcase
    end

    // Vy is not registered: it arrives on rf_rdata during EXEC and feeds the ALU directly.
    assign shift_src = SHIFT_SRC_VY ? rf_rdata : vx_q;

    always_comb begin
        alu_sel = ALU_f_OR;
        opa     = 8'h00;
        opb     = 8'h00;
        if (state == S_EXEC) begin
            case (op_n)
                4'h0: begin alu_sel = ALU_f_OR;     opa = rf_rdata;  opb = 8'h00;    end
                4'h1: begin alu_sel = ALU_f_OR;     opa = vx_q;      opb = rf_rdata; end
                4'h2: begin alu_sel = ALU_f_AND;    opa = vx_q;      opb = rf_rdata; end
                4'h3: begin alu_sel = ALU_f_XOR;    opa = vx_q;      opb = rf_rdata; end
                4'h4: begin alu_sel = ALU_f_ADD;    opa = vx_q;      opb = rf_rdata; end
                4'h5: begin alu_sel = ALU_f_MINUS;  opa = vx_q;      opb = rf_rdata; end
                4'h7: begin alu_sel = ALU_f_MINUS;  opa = rf_rdata;  opb = vx_q;     end
                4'h6: begin alu_sel = ALU_f_RSHIFT; opa = shift_src; opb = 8'h01;    end
                4'hE: begin alu_sel = ALU_f_LSHIFT; opa = shift_src; opb = 8'h01;    end
                default: begin alu_sel = ALU_f_OR;  opa = 8'h00;     opb = 8'h00;    end
            endcase
        end
    end

    assign alu_in1 = {8'h00, opa};
    assign alu_in2 = {8'h00, opb};

    always_comb begin
        flag_d = 1'b0;
        case (op_n)
            4'h4:       flag_d = alu_out[8];
            4'h5, 4'h7: flag_d = ~alu_out[15];
            4'h6:       flag_d = shift_src[0];
            4'hE:       flag_d = shift_src[7];
            default:    flag_d = 1'b0;
        endcase
    end

    always_comb begin
        rf_wdata = 8'h00;
        case (state)
            S_WR_V:  rf_wdata = result_q;
            S_WR_F:  rf_wdata = {7'b0, flag_q};
            default: rf_wdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            op_q     <= 12'h000;
            vx_q     <= 8'h00;
            result_q <= 8'h00;
            flag_q   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            rf_raddr <= 4'h0;
            rf_we    <= 1'b0;
            rf_waddr <= 4'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q <= opcode[11:0];
                        busy <= 1'b1;
                        if (is_legal(opcode)) begin
                            rf_raddr <= opcode[11:8];
                            illegal  <= 1'b0;
                            state    <= S_RD_X;
                        end else begin
                            done    <= 1'b1;
                            illegal <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_RD_X: begin
                    rf_raddr <= op_y;
                    state    <= S_RD_Y;
                end
                S_RD_Y: begin
                    vx_q  <= rf_rdata;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    result_q <= alu_out[7:0];
                    flag_q   <= flag_d;
                    rf_we    <= 1'b1;
                    rf_waddr <= op_x;
                    state    <= S_WR_V;
                end
                S_WR_V: begin
                    if (flag_op) begin
                        rf_waddr <= 4'hF;
                        state    <= S_WR_F;
                    end else begin
                        rf_we <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_WR_F: begin
                    rf_we <= 1'b0;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    illegal <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// Directed bench: two sequencer instances (default parameters and
// SHIFT_SRC_VY=1/LOGIC_CLR_VF=1) each with its own register file and ALU model.
module tb_chip8_alu_sequencer;
    import chip8_alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [1:0]       start;
    logic [1:0][15:0] opcode;
    logic [1:0]       busy_o, done_o, ill_o, we_o;
    logic [1:0][3:0]  raddr, waddr, sel_raw;
    logic [1:0][7:0]  rdata, wdata;
    logic [1:0][15:0] in1, in2, aout;
    logic [7:0]       rf [2][16];

    int total = 0;
    int bad   = 0;

    int          obs_done;
    logic        obs_ill;
    bit          busy_ok;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];

    chip8_alu_sequencer #(.SHIFT_SRC_VY(1'b0), .LOGIC_CLR_VF(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .opcode(opcode[0]),
        .busy(busy_o[0]), .done(done_o[0]), .illegal(ill_o[0]),
        .rf_raddr(raddr[0]), .rf_rdata(rdata[0]), .rf_we(we_o[0]),
        .rf_waddr(waddr[0]), .rf_wdata(wdata[0]),
        .alu_in1(in1[0]), .alu_in2(in2[0]), .alu_sel(sel_raw[0]), .alu_out(aout[0])
    );

    chip8_alu_sequencer #(.SHIFT_SRC_VY(1'b1), .LOGIC_CLR_VF(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .opcode(opcode[1]),
        .busy(busy_o[1]), .done(done_o[1]), .illegal(ill_o[1]),
        .rf_raddr(raddr[1]), .rf_rdata(rdata[1]), .rf_we(we_o[1]),
        .rf_waddr(waddr[1]), .rf_wdata(wdata[1]),
        .alu_in1(in1[1]), .alu_in2(in2[1]), .alu_sel(sel_raw[1]), .alu_out(aout[1])
    );

    function automatic logic [15:0] alu_f(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
        case (ALU_f'(s))
            ALU_f_OR:     return a | b;
            ALU_f_AND:    return a & b;
            ALU_f_XOR:    return a ^ b;
            ALU_f_ADD:    return a + b;
            ALU_f_MINUS:  return a - b;
            ALU_f_RSHIFT: return a >> b;
            ALU_f_LSHIFT: return a << b;
            default:      return 16'h0000;
        endcase
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++) aout[d] = alu_f(sel_raw[d], in1[d], in2[d]);
    end

    // Register-file model: synchronous read, write on rising edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rdata[d] <= rf[d][raddr[d]];
            if (we_o[d] === 1'b1) rf[d][waddr[d]] = wdata[d];
        end
    end

    // Driver: issues one start and collects writes/done until one cycle after done.
    task automatic run_op(input int d, input logic [15:0] op, input bit skip_wait,
                          input int poke_cyc, input logic [15:0] poke_op);
        obs_q.delete();
        obs_done = -1;
        obs_ill  = 1'b0;
        busy_ok  = 1'b1;
        if (!skip_wait) @(negedge clk);
        opcode[d] = op;
        start[d]  = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            if (busy_o[d] !== 1'b1) busy_ok = 1'b0;
            if (we_o[d] === 1'b1) obs_q.push_back({k[3:0], waddr[d], wdata[d]});
            if (done_o[d] === 1'b1) begin
                obs_done = k;
                obs_ill  = ill_o[d];
                break;
            end
            start[d] = (k == poke_cyc);
            if (k == poke_cyc) opcode[d] = poke_op;
            @(negedge clk);
        end
        start[d] = 1'b0;
        @(negedge clk);
        if (busy_o[d] !== 1'b0 || done_o[d] !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [51:0] outs;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                reset_n = 1'b1;
                @(negedge clk);
            end
            for (int d = 0; d < 2; d++) begin
                outs = {busy_o[d], done_o[d], ill_o[d], we_o[d], raddr[d], waddr[d], wdata[d], in1[d], in2[d]};
                total++;
                if (outs !== 52'h0) begin
                    bad++;
                    $display("FAIL reset_outs dut%0d phase%0d got=%h exp=0", d, ph, outs);
                end
                total++;
                if (sel_raw[d] !== ALU_f_OR) begin
                    bad++;
                    $display("FAIL reset_alu_sel dut%0d got=%h exp=%h", d, sel_raw[d], ALU_f_OR);
                end
            end
        end
    endtask

    task automatic test_alu_ops();
        int          vd   [15] = '{0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        logic [15:0] vop  [15] = '{16'h8124, 16'h8345, 16'h8345, 16'h8F5E, 16'h8121, 16'h8121, 16'h8676,
                                   16'h8676, 16'h8897, 16'h8A90, 16'h8AB2, 16'h8AB3, 16'h8CDE, 16'h8124, 16'h8124};
        logic [7:0]  vxv  [15] = '{8'hF0, 8'h10, 8'h20, 8'hFF, 8'h0C, 8'h0C, 8'h81,
                                   8'h81, 8'h10, 8'h55, 8'hF0, 8'hF0, 8'h81, 8'hFF, 8'h01};
        logic [7:0]  vyv  [15] = '{8'h20, 8'h20, 8'h20, 8'h81, 8'h30, 8'h30, 8'h03,
                                   8'h03, 8'h30, 8'h30, 8'h3C, 8'h3C, 8'h00, 8'h01, 8'h01};
        logic [7:0]  vres [15] = '{8'h10, 8'hF0, 8'h00, 8'h02, 8'h3C, 8'h3C, 8'h40,
                                   8'h01, 8'h20, 8'h30, 8'h30, 8'hCC, 8'h02, 8'h00, 8'h02};
        bit          vfw  [15] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1};
        bit          vfl  [15] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
        int d;
        int exp_done;
        logic [3:0] x, y;
        for (int i = 0; i < 15; i++) begin
            d = vd[i];
            x = vop[i][11:8];
            y = vop[i][7:4];
            rf[d][x] = vxv[i];
            rf[d][y] = vyv[i];
            exp_q.delete();
            exp_q.push_back({4'h4, x, vres[i]});
            if (vfw[i]) exp_q.push_back({4'h5, 4'hF, 7'b0, vfl[i]});
            exp_done = vfw[i] ? 6 : 5;
            run_op(d, vop[i], 1'b0, 0, 16'h0);
            total++;
            if (obs_done !== exp_done) begin
                bad++;
                $display("FAIL op%0d_done_cycle op=%h got=%0d exp=%0d", i, vop[i], obs_done, exp_done);
            end
            total++;
            if (obs_ill !== 1'b0) begin
                bad++;
                $display("FAIL op%0d_illegal op=%h got=%b exp=0", i, vop[i], obs_ill);
            end
            total++;
            if (!busy_ok) begin
                bad++;
                $display("FAIL op%0d_busy_window op=%h got=bad exp=ok", i, vop[i]);
            end
            total++;
            if (obs_q.size() != exp_q.size()) begin
                bad++;
                $display("FAIL op%0d_write_count op=%h got=%0d exp=%0d", i, vop[i], obs_q.size(), exp_q.size());
            end
            for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
                total++;
                if (obs_q[j] !== exp_q[j]) begin
                    bad++;
                    $display("FAIL op%0d_write%0d {cyc,addr,data} got=%h exp=%h", i, j, obs_q[j], exp_q[j]);
                end
            end
            total++;
            if (vfw[i] ? (rf[d][15] !== {7'b0, vfl[i]}) : (rf[d][x] !== vres[i])) begin
                bad++;
                $display("FAIL op%0d_final_reg got=%h/%h exp=%h/%h", i, rf[d][x], rf[d][15], vres[i], vfl[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [15:0] ops [4] = '{16'h8AB9, 16'h7123, 16'h8AB8, 16'h0124};
        for (int i = 0; i < 4; i++) begin
            run_op(i % 2, ops[i], 1'b0, 0, 16'h0);
            total++;
            if (obs_done !== 1 || obs_ill !== 1'b1) begin
                bad++;
                $display("FAIL illegal%0d op=%h got=done%0d/ill%b exp=done1/ill1", i, ops[i], obs_done, obs_ill);
            end
            total++;
            if (obs_q.size() != 0 || !busy_ok) begin
                bad++;
                $display("FAIL illegal%0d_quiet op=%h got=writes%0d/busy_ok%0d exp=0/1", i, ops[i], obs_q.size(), busy_ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        rf[0][1] = 8'hF0;
        rf[0][2] = 8'h20;
        rf[0][3] = 8'h10;
        rf[0][4] = 8'h20;
        exp_q.delete();
        exp_q.push_back({4'h4, 4'h1, 8'h10});
        exp_q.push_back({4'h5, 4'hF, 8'h01});
        run_op(0, 16'h8124, 1'b0, 2, 16'h8345);
        total++;
        if (obs_done !== 6 || obs_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_first got=done%0d/writes%0d exp=done6/writes2", obs_done, obs_q.size());
        end else if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
            bad++;
            $display("FAIL b2b_first_writes got=%h,%h exp=%h,%h", obs_q[0], obs_q[1], exp_q[0], exp_q[1]);
        end
        exp_q.delete();
        exp_q.push_back({4'h4, 4'h3, 8'hF0});
        exp_q.push_back({4'h5, 4'hF, 8'h00});
        run_op(0, 16'h8345, 1'b1, 0, 16'h0);
        total++;
        if (obs_done !== 6 || obs_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_second got=done%0d/writes%0d exp=done6/writes2", obs_done, obs_q.size());
        end else if (obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
            bad++;
            $display("FAIL b2b_second_writes got=%h,%h exp=%h,%h", obs_q[0], obs_q[1], exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [51:0] outs;
        int          wr_seen;
        rf[0][1]  = 8'hF0;
        rf[0][2]  = 8'h20;
        rf[0][15] = 8'hAA;
        wr_seen   = 0;
        @(negedge clk);
        opcode[0] = 16'h8124;
        start[0]  = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        total++;
        if (in1[0] !== 16'h00F0) begin
            bad++;
            $display("FAIL mid_exec_alu_in1 got=%h exp=00f0", in1[0]);
        end
        reset_n = 1'b0;
        #1;
        outs = {busy_o[0], done_o[0], ill_o[0], we_o[0], raddr[0], waddr[0], wdata[0], in1[0], in2[0]};
        total++;
        if (outs !== 52'h0 || sel_raw[0] !== ALU_f_OR) begin
            bad++;
            $display("FAIL mid_reset_outs got=%h sel=%h exp=0 sel=%h", outs, sel_raw[0], ALU_f_OR);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) reset_n = 1'b1;
            if (we_o[0] !== 1'b0) wr_seen++;
        end
        total++;
        if (wr_seen != 0 || rf[0][1] !== 8'hF0 || rf[0][15] !== 8'hAA) begin
            bad++;
            $display("FAIL mid_reset_no_write got=we%0d/V1=%h/VF=%h exp=we0/V1=f0/VF=aa", wr_seen, rf[0][1], rf[0][15]);
        end
        run_op(0, 16'h8124, 1'b0, 0, 16'h0);
        total++;
        if (obs_done !== 6 || rf[0][1] !== 8'h10 || rf[0][15] !== 8'h01) begin
            bad++;
            $display("FAIL mid_reset_restart got=done%0d/V1=%h/VF=%h exp=done6/V1=10/VF=01", obs_done, rf[0][1], rf[0][15]);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = '0;
        opcode  = '0;
        for (int d = 0; d < 2; d++)
            for (int r = 0; r < 16; r++) rf[d][r] = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_alu_ops();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chip8_alu_sequencer.md
Name: chip8_alu_sequencer

Overview:
Multi-cycle executor for Chip-8 8XYN arithmetic/logic instructions, instantiated inside the CPU between the V-register file and the combinational Chip-8 ALU. On a start pulse it:
- latches the opcode;
- reads Vx and Vy over a single synchronous read port;
- drives the ALU with the correct ALU_f function and zero-extended operands;
- writes the 8-bit result to Vx, then the flag to VF where the instruction defines one;
- pulses done.

Parameters:
SHIFT_SRC_VY, 0, 0: 8XY6/8XYE shift Vx; 1: shift Vy and write result to Vx (COSMAC behaviour).
LOGIC_CLR_VF, 0, 1: 8XY1/8XY2/8XY3 additionally write VF=0; 0: VF untouched.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
opcode  in  16  instruction word, latched when start is accepted
busy  out  1  high from accept until done cycle inclusive
done  out  1  one-cycle completion pulse
illegal  out  1  valid with done; 1 = opcode not executed
rf_raddr  out  4  register-file read address; rf_rdata valid the cycle after
rf_rdata  in  8  register-file read data
rf_we  out  1  register-file write enable
rf_waddr  out  4  write address
rf_wdata  out  8  write data
alu_in1  out  16  ALU operand 1, {8'h00, a}
alu_in2  out  16  ALU operand 2, {8'h00, b}
alu_sel  out  ALU_f  ALU function select
alu_out  in  16  ALU result; alu_carry is not used

Behaviour:
- Reset (async, reset_n=0): state=IDLE.
  - busy=0, done=0, illegal=0, rf_we=0, rf_raddr=0, rf_waddr=0, rf_wdata=0.
  - alu_in1=alu_in2=0, alu_sel=ALU_f_OR.
  - Latched vx/vy/result/flag registers = 0.
  - Reset mid-operation abandons the instruction; no further writes occur.
- States: IDLE -> RD_X -> RD_Y -> EXEC -> WR_V -> [WR_F] -> DONE -> IDLE.
- IDLE: on start=1, latch opcode and go to RD_X. If opcode[15:12]!=4'h8, or N is not in {0,1,2,3,4,5,6,7,E}, go directly to DONE with illegal=1 and no reads or writes.
- RD_X: rf_raddr=X.
- RD_Y: capture vx<=rf_rdata; rf_raddr=Y.
- EXEC: capture vy; drive the ALU combinationally; register result<=alu_out[7:0] and flag at the end of this cycle.
- N mapping (a,b = ALU operands):
  - 0 LD: result=vy via ALU_f_OR with a=vy, b=0. No flag write.
  - 1/2/3 OR/AND/XOR: a=vx, b=vy. Flag write only if LOGIC_CLR_VF=1, flag=0.
  - 4 ADD: a=vx, b=vy, ALU_f_ADD. flag=alu_out[8].
  - 5 SUB: a=vx, b=vy, ALU_f_MINUS. flag=~alu_out[15] (1 when vx>=vy).
  - 7 SUBN: a=vy, b=vx, ALU_f_MINUS. flag=~alu_out[15].
  - 6 SHR: src=vx (or vy per SHIFT_SRC_VY), ALU_f_RSHIFT, b=1. flag=src[0].
  - E SHL: same source selection, ALU_f_LSHIFT, b=1. Result truncated to 8 bits. flag=src[7].
- WR_V: rf_we=1, rf_waddr=X, rf_wdata=result.
- WR_F: entered only for flag-writing ops. rf_we=1, rf_waddr=4'hF, rf_wdata={7'b0,flag}.
- Write ordering is fixed: Vx first, VF last. When X=F, the final VF value is the flag.
- DONE: done=1 for exactly one cycle, illegal held valid with it; busy drops the following cycle.
- Latency, counted in cycles after the edge that samples start:
  - done in cycle 5 for non-flag ops;
  - done in cycle 6 for flag ops;
  - done in cycle 1 for illegal opcodes.
- start while busy is ignored; no queueing. start is accepted again in the first IDLE cycle after DONE.
- rf_we is never asserted outside WR_V/WR_F. At most 2 writes per instruction.

Test Plan:
- V1=0xF0, V2=0x20; opcode 0x8124 -> V1=0x10 written cycle 4, VF=0x01 written cycle 5, done cycle 6, illegal=0.
- V3=0x10, V4=0x20; 0x8345 -> V3=0xF0, VF=0x00. Then V3=0x20, V4=0x20; 0x8345 -> V3=0x00, VF=0x01.
- VF=0xFF, V5=0x81; 0x8F5E with SHIFT_SRC_VY=1 -> VF write of 0x02 then VF write of 0x01; final VF=0x01.
- 0x8AB9 and 0x7123 -> done=1, illegal=1 in cycle 1; rf_we never asserted; busy high only for that cycle.
- 0x8121 with LOGIC_CLR_VF=0 -> exactly one write (V1), done cycle 5. With LOGIC_CLR_VF=1 -> V1 write then VF=0x00, done cycle 6.
- Start 0x8124; assert start again in cycle 2 (ignored); drop reset_n in cycle 3 -> all outputs return to reset values immediately, no writes occur, and a fresh start after reset release executes normally.
